mdio_request_arbiter: RTL and testbench

//  Shares the single management-port MDIO transceiver between NUM_REQ independent requesters (register interface,

---
 rtl/mdio_request_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_mdio_request_arbiter.sv | 506 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_request_arbiter.sv
// ---------------------------------------------------------------------------
// mdio_request_arbiter
//
// Shares one MDIO transceiver between NUM_REQ independent requesters (register
// interface, link poller, PHY init sequencer). Requesters are served
// round-robin with a single transaction in flight. The arbiter issues a
// one-cycle read or write strobe to the transceiver and follows its busy
// handshake. It then returns read data, or a timeout error, to the requester
// that was granted.
//
// Ports
//   sys_clk, rst        management clock, asynchronous active-high reset
//   req_valid           per-requester pending flag (fields held until ready)
//   req_write           per-requester 1 = write, 0 = read
//   req_md_addr         PHY address, slice [5*i +: 5]
//   req_reg_addr        register address, slice [5*i +: 5]
//   req_wdata           write data, slice [16*i +: 16]
//   req_ready           one-cycle accept pulse, at most one bit set
//   resp_valid          one-cycle completion pulse to the granted requester
//   resp_error          transaction timed out (qualified by resp_valid)
//   resp_rdata          read data, 0 for writes and errors (qualified)
//   arb_busy            high from accept through the response cycle
//   phy_md_addr         PHY address to the transceiver
//   phy_reg_addr        register address to the transceiver
//   phy_wr_data         write data to the transceiver
//   phy_reg_wr          one-cycle write strobe to the transceiver
//   phy_reg_rd          one-cycle read strobe to the transceiver
//   mdio_busy           transceiver busy indication
//   phy_rd_data         transceiver read data, valid when busy falls
// ---------------------------------------------------------------------------
module mdio_request_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int START_TIMEOUT = 16,
  parameter int OP_TIMEOUT    = 8192
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [5*NUM_REQ-1:0]    req_md_addr,
  input  logic [5*NUM_REQ-1:0]    req_reg_addr,
  input  logic [16*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic                    resp_error,
  output logic [15:0]             resp_rdata,
  output logic                    arb_busy,
  output logic [4:0]              phy_md_addr,
  output logic [4:0]              phy_reg_addr,
  output logic [15:0]             phy_wr_data,
  output logic                    phy_reg_wr,
  output logic                    phy_reg_rd,
  input  logic                    mdio_busy,
  input  logic [15:0]             phy_rd_data
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_RAW = ($clog2(OP_TIMEOUT) > $clog2(START_TIMEOUT)) ?
                           $clog2(OP_TIMEOUT) : $clog2(START_TIMEOUT);
  localparam int CNT_W   = (CNT_RAW > 0) ? CNT_RAW : 1;

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] OP_LAST    = CNT_W'(OP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_WAIT_DONE,
    S_RESPOND
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic             write_q, write_d;
  logic [4:0]       md_q, md_d;
  logic [4:0]       reg_q, reg_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             resp_error_q, resp_error_d;
  logic [15:0]      resp_rdata_q, resp_rdata_d;

  logic [IDX_W-1:0] winner;
  logic             found;
  int               cand;
  logic             sel_write;
  logic [4:0]       sel_md;
  logic [4:0]       sel_reg;
  logic [15:0]      sel_wdata;
  logic             grant_any;

  // Round-robin search: start one past the last served requester and take the
  // first pending bit, wrapping at NUM_REQ. The winner's fields are muxed out
  // with constant slices so that no variable part-select is needed.
  always_comb begin
    winner    = '0;
    found     = 1'b0;
    cand      = 0;
    sel_write = 1'b0;
    sel_md    = '0;
    sel_reg   = '0;
    sel_wdata = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = int'(last_grant_q) + off;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!found && req_valid[IDX_W'(cand)]) begin
        winner = IDX_W'(cand);
        found  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDX_W'(i)) begin
        sel_write = req_write[i];
        sel_md    = req_md_addr[5*i +: 5];
        sel_reg   = req_reg_addr[5*i +: 5];
        sel_wdata = req_wdata[16*i +: 16];
      end
    end
  end

  // A grant is only given while the transceiver is idle. This also covers a
  // late busy-fall after a timeout, or an op left running across a reset.
  // The reset term keeps req_ready/arb_busy low while reset is held, even
  // though the state register already reads IDLE.
  assign grant_any = (state_q == S_IDLE) && found && !mdio_busy && !rst;

  // Next-state logic for the transaction sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    write_d      = write_q;
    md_d         = md_q;
    reg_d        = reg_q;
    wdata_d      = wdata_q;
    resp_error_d = resp_error_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          state_d = S_ISSUE;
          grant_d = winner;
          write_d = sel_write;
          md_d    = sel_md;
          reg_d   = sel_reg;
          wdata_d = sel_wdata;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (mdio_busy) begin
          state_d = S_WAIT_DONE;
          cnt_d   = '0;
        end else if (cnt_q == START_LAST) begin
          state_d      = S_RESPOND;
          resp_error_d = 1'b1;
          resp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!mdio_busy) begin
          state_d      = S_RESPOND;
          resp_error_d = 1'b0;
          resp_rdata_d = write_q ? 16'h0000 : phy_rd_data;
        end else if (cnt_q == OP_LAST) begin
          state_d      = S_RESPOND;
          resp_error_d = 1'b1;
          resp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESPOND: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. last_grant resets to the highest index so
  // that requester 0 wins the first arbitration after reset.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      write_q      <= 1'b0;
      md_q         <= '0;
      reg_q        <= '0;
      wdata_q      <= '0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      write_q      <= write_d;
      md_q         <= md_d;
      reg_q        <= reg_d;
      wdata_q      <= wdata_d;
      resp_error_q <= resp_error_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Outputs are decoded from the state register. An asynchronous reset
  // forces IDLE, so every output drops in the same cycle the reset arrives.
  always_comb begin
    req_ready    = grant_any ? (NUM_REQ'(1) << winner) : '0;
    resp_valid   = (state_q == S_RESPOND) ? (NUM_REQ'(1) << grant_q) : '0;
    resp_error   = resp_error_q;
    resp_rdata   = resp_rdata_q;
    arb_busy     = (state_q != S_IDLE) || grant_any;
    phy_reg_wr   = (state_q == S_ISSUE) && write_q;
    phy_reg_rd   = (state_q == S_ISSUE) && !write_q;
    phy_md_addr  = (state_q != S_IDLE) ? md_q    : '0;
    phy_reg_addr = (state_q != S_IDLE) ? reg_q   : '0;
    phy_wr_data  = (state_q != S_IDLE) ? wdata_q : '0;
  end

endmodule

// File: tb/tb_mdio_request_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mdio_request_arbiter
//
// Self-checking bench for mdio_request_arbiter with two requesters. A
// behavioural transceiver model raises and drops mdio_busy after each strobe.
// Expected responses are queued at accept time and popped when resp_valid
// fires.
// ---------------------------------------------------------------------------
module tb_mdio_request_arbiter;

  localparam int NREQ = 2;
  localparam int ST   = 16;
  localparam int OT   = 8192;

  typedef struct {
    int          idx;
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  logic              sys_clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_write;
  logic [5*NREQ-1:0] req_md_addr;
  logic [5*NREQ-1:0] req_reg_addr;
  logic [16*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   resp_valid;
  logic              resp_error;
  logic [15:0]       resp_rdata;
  logic              arb_busy;
  logic [4:0]        phy_md_addr;
  logic [4:0]        phy_reg_addr;
  logic [15:0]       phy_wr_data;
  logic              phy_reg_wr;
  logic              phy_reg_rd;
  logic              mdio_busy;
  logic [15:0]       phy_rd_data;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;
  int   wr_pulses    = 0;
  int   rd_pulses    = 0;
  int   last_resp_cyc = -1;
  int   rise_cyc     = -1;
  int   fall_cyc     = -1;
  int   model_mode   = 0;
  int   rise_dly     = 2;
  int   fall_dly     = 100;
  logic stuck_release = 1'b0;
  exp_t sb[$];

  mdio_request_arbiter #(
    .NUM_REQ(NREQ),
    .START_TIMEOUT(ST),
    .OP_TIMEOUT(OT)
  ) dut (
    .sys_clk(sys_clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_md_addr(req_md_addr),
    .req_reg_addr(req_reg_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .resp_valid(resp_valid),
    .resp_error(resp_error),
    .resp_rdata(resp_rdata),
    .arb_busy(arb_busy),
    .phy_md_addr(phy_md_addr),
    .phy_reg_addr(phy_reg_addr),
    .phy_wr_data(phy_wr_data),
    .phy_reg_wr(phy_reg_wr),
    .phy_reg_rd(phy_reg_rd),
    .mdio_busy(mdio_busy),
    .phy_rd_data(phy_rd_data)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Transceiver model. Mode 0 raises busy rise_dly cycles after a strobe and
  // drops it fall_dly cycles later. Mode 1 never answers. Mode 2 raises busy
  // and holds it until stuck_release is set.
  initial begin
    mdio_busy = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (phy_reg_wr || phy_reg_rd) begin
        if (model_mode == 0) begin
          repeat (rise_dly) @(negedge sys_clk);
          mdio_busy = 1'b1;
          rise_cyc  = cyc;
          repeat (fall_dly) @(negedge sys_clk);
          mdio_busy = 1'b0;
          fall_cyc  = cyc;
        end else if (model_mode == 2) begin
          repeat (2) @(negedge sys_clk);
          mdio_busy = 1'b1;
          rise_cyc  = cyc;
          while (!stuck_release) @(negedge sys_clk);
          mdio_busy = 1'b0;
          fall_cyc  = cyc;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic void push_exp(input int idx, input logic err, input logic [15:0] rdata);
    exp_t e;
    e.idx   = idx;
    e.err   = err;
    e.rdata = rdata;
    sb.push_back(e);
  endfunction

  // Called at a falling edge; returns at falling edge + 1 of the accept cycle.
  task automatic wait_ready(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      #1;
      if (req_ready != '0) begin
        ok = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
  endtask

  task automatic wait_sb_empty(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge sys_clk);
      #2;
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    req_valid    = '0;
    req_write    = '0;
    req_md_addr  = '0;
    req_reg_addr = '0;
    req_wdata    = '0;
    phy_rd_data  = '0;
    repeat (3) @(negedge sys_clk);
    req_valid = 2'b11;
    #1;
    tests_run++;
    if ({req_ready, resp_valid, resp_error, arb_busy, phy_reg_wr, phy_reg_rd} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: got %b, want 0",
               {req_ready, resp_valid, resp_error, arb_busy, phy_reg_wr, phy_reg_rd});
    end
    tests_run++;
    if ({resp_rdata, phy_md_addr, phy_reg_addr, phy_wr_data} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: got %h, want 0",
               {resp_rdata, phy_md_addr, phy_reg_addr, phy_wr_data});
    end
    @(negedge sys_clk);
    req_valid = '0;
    rst       = 1'b0;
  endtask

  task automatic test_single_read();
    bit ok;
    int acc;
    model_mode  = 0;
    rise_dly    = 2;
    fall_dly    = 100;
    phy_rd_data = 16'h7949;
    @(negedge sys_clk);
    req_write[0]        = 1'b0;
    req_md_addr[4:0]    = 5'd1;
    req_reg_addr[4:0]   = 5'd1;
    req_valid           = 2'b01;
    wait_ready(20, ok);
    acc = cyc;
    tests_run++;
    if (!ok || req_ready !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL read_accept: got ready %b, want 01", req_ready);
    end
    push_exp(0, 1'b0, 16'h7949);
    @(negedge sys_clk);
    req_valid = '0;
    #1;
    tests_run++;
    if ({phy_reg_rd, phy_reg_wr, phy_md_addr, phy_reg_addr} !== {1'b1, 1'b0, 5'd1, 5'd1}) begin
      tests_failed++;
      $display("[TB] FAIL read_strobe: got rd=%b wr=%b md=%0d reg=%0d at cycle %0d, want rd=1 wr=0 md=1 reg=1 at %0d",
               phy_reg_rd, phy_reg_wr, phy_md_addr, phy_reg_addr, cyc, acc + 1);
    end
    wait_sb_empty(300, ok);
    tests_run++;
    if (!ok || last_resp_cyc !== fall_cyc + 1) begin
      tests_failed++;
      $display("[TB] FAIL read_latency: got resp at cycle %0d, want %0d", last_resp_cyc, fall_cyc + 1);
    end
  endtask

  task automatic test_write();
    bit ok;
    bit stable_ok;
    int wr0;
    int rd0;
    model_mode  = 0;
    rise_dly    = 2;
    fall_dly    = 20;
    phy_rd_data = 16'hBEEF;
    @(negedge sys_clk);
    wr0 = wr_pulses;
    rd0 = rd_pulses;
    req_write[1]        = 1'b1;
    req_md_addr[9:5]    = 5'd3;
    req_reg_addr[9:5]   = 5'd0;
    req_wdata[31:16]    = 16'h1140;
    req_valid           = 2'b10;
    wait_ready(20, ok);
    tests_run++;
    if (!ok || req_ready !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL write_accept: got ready %b, want 10", req_ready);
    end
    push_exp(1, 1'b0, 16'h0000);
    stable_ok = 1'b1;
    ok        = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      req_valid = '0;
      #1;
      if (phy_wr_data !== 16'h1140 || phy_md_addr !== 5'd3) stable_ok = 1'b0;
      if (resp_valid != '0) begin
        ok = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!ok || !stable_ok) begin
      tests_failed++;
      $display("[TB] FAIL write_data_stable: got resp_seen=%b stable=%b, want 1 1", ok, stable_ok);
    end
    @(negedge sys_clk);
    #1;
    tests_run++;
    if (phy_wr_data !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL write_data_idle: got %h, want 0000", phy_wr_data);
    end
    tests_run++;
    if ((wr_pulses - wr0) !== 1 || (rd_pulses - rd0) !== 0) begin
      tests_failed++;
      $display("[TB] FAIL write_pulses: got wr=%0d rd=%0d, want wr=1 rd=0",
               wr_pulses - wr0, rd_pulses - rd0);
    end
    wait_sb_empty(20, ok);
  endtask

  task automatic test_round_robin();
    bit ok;
    int expect_idx;
    int prev_acc;
    bit gap_ok;
    model_mode  = 0;
    rise_dly    = 1;
    fall_dly    = 1;
    phy_rd_data = 16'h1234;
    expect_idx  = 0;
    prev_acc    = -1;
    gap_ok      = 1'b1;
    @(negedge sys_clk);
    req_write         = 2'b10;
    req_md_addr[4:0]  = 5'd2;
    req_reg_addr[4:0] = 5'd5;
    req_wdata[31:16]  = 16'h00AA;
    req_valid         = 2'b11;
    for (int n = 0; n < 6; n++) begin
      wait_ready(40, ok);
      tests_run++;
      if (!ok || req_ready !== (2'b01 << expect_idx)) begin
        tests_failed++;
        $display("[TB] FAIL rr_grant%0d: got ready %b, want %b", n, req_ready, 2'b01 << expect_idx);
      end
      if (prev_acc >= 0 && (cyc - prev_acc) != 5) gap_ok = 1'b0;
      prev_acc = cyc;
      push_exp(expect_idx, 1'b0, (expect_idx == 0) ? 16'h1234 : 16'h0000);
      expect_idx = 1 - expect_idx;
      @(negedge sys_clk);
    end
    req_valid = '0;
    tests_run++;
    if (!gap_ok) begin
      tests_failed++;
      $display("[TB] FAIL rr_spacing: got non-5-cycle accept spacing, want 5");
    end
    wait_sb_empty(40, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("[TB] FAIL rr_drain: got %0d pending responses, want 0", sb.size());
    end
  endtask

  task automatic test_start_timeout();
    bit ok;
    int acc;
    model_mode = 1;
    @(negedge sys_clk);
    req_write[0] = 1'b0;
    req_valid    = 2'b01;
    wait_ready(20, ok);
    acc = cyc;
    push_exp(0, 1'b1, 16'h0000);
    @(negedge sys_clk);
    req_valid = '0;
    wait_sb_empty(ST + 20, ok);
    tests_run++;
    if (!ok || last_resp_cyc !== acc + 1 + ST + 1) begin
      tests_failed++;
      $display("[TB] FAIL start_timeout: got resp at %0d, want %0d", last_resp_cyc, acc + ST + 2);
    end
    model_mode  = 0;
    rise_dly    = 2;
    fall_dly    = 5;
    phy_rd_data = 16'h0C0C;
    req_write[1] = 1'b0;
    req_valid    = 2'b10;
    wait_ready(20, ok);
    tests_run++;
    if (!ok || req_ready !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL after_start_timeout: got ready %b, want 10", req_ready);
    end
    push_exp(1, 1'b0, 16'h0C0C);
    @(negedge sys_clk);
    req_valid = '0;
    wait_sb_empty(40, ok);
  endtask

  task automatic test_op_timeout();
    bit ok;
    int grants;
    model_mode    = 2;
    stuck_release = 1'b0;
    @(negedge sys_clk);
    req_write[1]     = 1'b1;
    req_wdata[31:16] = 16'h5A5A;
    req_valid        = 2'b10;
    wait_ready(20, ok);
    push_exp(1, 1'b1, 16'h0000);
    @(negedge sys_clk);
    req_valid = '0;
    wait_sb_empty(OT + 50, ok);
    tests_run++;
    if (!ok || last_resp_cyc !== rise_cyc + 1 + OT) begin
      tests_failed++;
      $display("[TB] FAIL op_timeout: got resp at %0d, want %0d", last_resp_cyc, rise_cyc + 1 + OT);
    end
    req_write[0] = 1'b0;
    req_valid    = 2'b01;
    grants       = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      #1;
      if (req_ready != '0 || arb_busy) grants++;
    end
    tests_run++;
    if (grants !== 0) begin
      tests_failed++;
      $display("[TB] FAIL grant_while_busy: got %0d grant cycles, want 0", grants);
    end
    @(negedge sys_clk);
    model_mode    = 0;
    rise_dly      = 2;
    fall_dly      = 5;
    phy_rd_data   = 16'hA5A5;
    stuck_release = 1'b1;
    wait_ready(20, ok);
    tests_run++;
    if (!ok || req_ready !== 2'b01 || mdio_busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL grant_after_release: got ready %b busy %b, want 01 0", req_ready, mdio_busy);
    end
    push_exp(0, 1'b0, 16'hA5A5);
    @(negedge sys_clk);
    req_valid = '0;
    wait_sb_empty(40, ok);
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    model_mode  = 0;
    rise_dly    = 2;
    fall_dly    = 100;
    phy_rd_data = 16'h3C3C;
    @(negedge sys_clk);
    req_write[1]      = 1'b0;
    req_md_addr[9:5]  = 5'd7;
    req_reg_addr[9:5] = 5'd9;
    req_valid         = 2'b10;
    wait_ready(20, ok);
    push_exp(1, 1'b0, 16'h3C3C);
    @(negedge sys_clk);
    req_valid = '0;
    for (int i = 0; i < 20 && !mdio_busy; i++) @(negedge sys_clk);
    repeat (3) @(negedge sys_clk);
    rst = 1'b1;
    sb.delete();
    #1;
    tests_run++;
    if ({req_ready, resp_valid, resp_error, arb_busy, phy_reg_wr, phy_reg_rd} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midop_reset_ctrl: got %b, want 0",
               {req_ready, resp_valid, resp_error, arb_busy, phy_reg_wr, phy_reg_rd});
    end
    tests_run++;
    if ({resp_rdata, phy_md_addr, phy_reg_addr, phy_wr_data} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midop_reset_data: got %h, want 0",
               {resp_rdata, phy_md_addr, phy_reg_addr, phy_wr_data});
    end
    @(negedge sys_clk);
    rst          = 1'b0;
    req_write[0] = 1'b0;
    req_valid    = 2'b11;
    wait_ready(300, ok);
    tests_run++;
    if (!ok || req_ready !== 2'b01 || mdio_busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_grant: got ready %b busy %b, want 01 0", req_ready, mdio_busy);
    end
    push_exp(0, 1'b0, 16'h3C3C);
    @(negedge sys_clk);
    req_valid = '0;
    wait_sb_empty(300, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_resp: got %0d pending responses, want 0", sb.size());
    end
  endtask

  initial begin
    // Response monitor: pops the scoreboard on every resp_valid and checks
    // that accept pulses are one-hot.
    fork
      forever begin
        @(negedge sys_clk);
        #1;
        if (!rst) begin
          if (phy_reg_wr) wr_pulses = wr_pulses + 1;
          if (phy_reg_rd) rd_pulses = rd_pulses + 1;
          if (req_ready != '0) begin
            tests_run++;
            if ($countones(req_ready) != 1) begin
              tests_failed++;
              $display("[TB] FAIL ready_onehot: got %b, want one bit", req_ready);
            end
          end
          if (resp_valid != '0) begin
            last_resp_cyc = cyc;
            tests_run++;
            if (sb.size() == 0) begin
              tests_failed++;
              $display("[TB] FAIL unexpected_resp: got resp_valid %b, want none", resp_valid);
            end else begin
              exp_t e;
              e = sb.pop_front();
              if (resp_valid !== (2'b01 << e.idx) || resp_error !== e.err || resp_rdata !== e.rdata) begin
                tests_failed++;
                $display("[TB] FAIL resp: got valid %b err %b rdata %h, want valid %b err %b rdata %h",
                         resp_valid, resp_error, resp_rdata, 2'b01 << e.idx, e.err, e.rdata);
              end
            end
          end
        end
      end
    join_none

    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_start_timeout();
    test_op_timeout();
    test_reset_mid_op();
    repeat (5) @(negedge sys_clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
